reg_dump: RTL
=============

Name: reg_dump

Overview:
- Readout engine for the 8-bit register file; drives the file's read address pointer and consumes its combinational read data.
- On a start pulse it walks an inclusive address range and streams each register byte out on a valid/ready byte interface.
- Used by the debug/test path to dump architectural state after a program run, with no core involvement.

Parameters:
- pw, 4, address pointer width; register file depth is 2**pw.

Ports:
- clk  input  1  single clock; all state on posedge clk.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- start  input  1  begin a dump; sampled in IDLE only.
- lo_addr  input  pw  first address of range; sampled with start.
- hi_addr  input  pw  last address of range, inclusive; sampled with start.
- rd_addr  output  pw  read pointer to the register file read port.
- rd_data  input  8  combinational read data returned for rd_addr.
- out_data  output  8  streamed byte.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  sink accepts the byte this cycle.
- out_last  output  1  marks the final byte of the dump; qualified by out_valid.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when the dump completes.

Behaviour:
- Reset (async): state=IDLE; rd_addr=0, out_data=0, out_valid=0, out_last=0, busy=0, done=0, hi_q=0, csum=0.
- States: IDLE, FETCH, SEND, DONE. CSUM is added under the optional feature.
- IDLE:
  - start=1 at an edge sets hi_q<=hi_addr, rd_addr<=lo_addr, csum<=0, and moves to FETCH.
  - start=0: stay in IDLE.
- FETCH (one cycle): out_data<=rd_data, out_valid<=1, out_last<=(rd_addr==hi_q && no CSUM stage), then SEND.
- SEND: a handshake is out_valid && out_ready at an edge.
  - No handshake: out_data, out_last and rd_addr hold stable.
  - Handshake with rd_addr!=hi_q: rd_addr<=rd_addr+1 (mod 2**pw), out_valid<=0, out_last<=0, go to FETCH.
  - Handshake with rd_addr==hi_q: out_valid<=0, out_last<=0, go to DONE (or CSUM when enabled).
- DONE: done=1 for exactly one cycle, busy=1, then IDLE. rd_addr retains its last value.
- Latency:
  - start at edge 0 gives out_valid=1 after edge 2.
  - Each subsequent byte appears 2 edges after the previous handshake, so one bubble per byte.
- Range:
  - Count = ((hi - lo) mod 2**pw) + 1.
  - hi<lo wraps through the top address to 0.
  - lo==hi sends one byte with out_last=1.
  - lo=0, hi=2**pw-1 sends the full file.
- Coherency: each byte is the register value sampled in its FETCH cycle. Writes to the file during a dump are visible for addresses not yet fetched. No atomic snapshot.
- start while busy is ignored, with no restart and no effect on the latched range.
- Reset mid-dump: out_valid drops immediately (asynchronously), no done pulse, returns to IDLE.
- out_valid never drops without a handshake except on reset.

Optional Feature:
- Macro: REG_DUMP_CHECKSUM_EN.
- Defined:
  - csum<=csum^out_data on every data handshake.
  - After the hi_q handshake, state CSUM presents out_data=csum (including the final byte), out_valid=1, out_last=1.
  - The CSUM handshake goes to DONE.
  - Data bytes never carry out_last.
- Undefined: no CSUM state or csum register; out_last accompanies the hi_q byte.

Test Plan:
- Preload r[i]=i*8'h11; start lo=2 hi=5, out_ready=1 -> bytes 22,33,44,55; out_last only with 55; done pulses once 1 cycle after the last handshake; busy falls with IDLE.
- Wrap: lo=14 hi=1 -> rd_addr sequence 14,15,0,1; bytes EE,FF,00,11; out_last on 11.
- Backpressure: hold out_ready=0 for 5 cycles on byte 33 -> out_data=33, out_valid=1, rd_addr=3 stable throughout; then resumes with 44.
- Single/ignore: lo=hi=7 -> one byte 77 with out_last=1. A second start during SEND is ignored, and no extra bytes follow the done pulse.
- Reset mid-SEND: assert reset between edges -> out_valid, busy, rd_addr go 0 without a clock; a new start afterwards dumps normally.
- REG_DUMP_CHECKSUM_EN: lo=1 hi=4 -> 11,22,33,44 with out_last=0, then checksum byte 44 with out_last=1, then done.

Source files
------------

// File: rtl/reg_dump.sv
// reg_dump: walks an inclusive register-file address range and streams each byte; REG_DUMP_CHECKSUM_EN appends an XOR checksum byte.
// Latency: first byte valid 2 cycles after start, then one bubble cycle between bytes; done pulses 1 cycle after the last handshake.
// Backpressure: out_data/out_last/rd_addr hold while out_valid && !out_ready; start is ignored while busy.
module reg_dump #(
    parameter int pw = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [pw-1:0] lo_addr,
    input  logic [pw-1:0] hi_addr,
    output logic [pw-1:0] rd_addr,
    input  logic [7:0]    rd_data,
    output logic [7:0]    out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_last,
    output logic          busy,
    output logic          done
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_SEND  = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
`ifdef REG_DUMP_CHECKSUM_EN
    localparam logic [2:0] S_CSUM  = 3'd4;
`endif

    logic [2:0]    state;
    logic [pw-1:0] hi_q;
    logic          hs;
    logic          at_hi;
`ifdef REG_DUMP_CHECKSUM_EN
    logic [7:0]    csum;
`endif

    assign hs    = out_valid && out_ready;
    assign at_hi = (rd_addr == hi_q);
    assign busy  = (state != S_IDLE);
    assign done  = (state == S_DONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            hi_q      <= '0;
            rd_addr   <= '0;
            out_data  <= 8'h00;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
            csum      <= 8'h00;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        hi_q    <= hi_addr;
                        rd_addr <= lo_addr;
`ifdef REG_DUMP_CHECKSUM_EN
                        csum    <= 8'h00;
`endif
                        state   <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    // rd_data is combinational off rd_addr, so this is the coherency point
                    out_data  <= rd_data;
                    out_valid <= 1'b1;
`ifdef REG_DUMP_CHECKSUM_EN
                    out_last  <= 1'b0;
`else
                    out_last  <= at_hi;
`endif
                    state     <= S_SEND;
                end
                S_SEND: begin
                    if (hs) begin
`ifdef REG_DUMP_CHECKSUM_EN
                        csum <= csum ^ out_data;
`endif
                        if (!at_hi) begin
                            rd_addr   <= rd_addr + pw'(1);
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            state     <= S_FETCH;
                        end else begin
`ifdef REG_DUMP_CHECKSUM_EN
                            // checksum byte folds in the final data byte and is presented at once
                            out_data  <= csum ^ out_data;
                            out_valid <= 1'b1;
                            out_last  <= 1'b1;
                            state     <= S_CSUM;
`else
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            state     <= S_DONE;
`endif
                        end
                    end
                end
`ifdef REG_DUMP_CHECKSUM_EN
                S_CSUM: begin
                    if (hs) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        state     <= S_DONE;
                    end
                end
`endif
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
